// File: rtl/arbitro_cancelas.sv
// arbitro_cancelas: round-robin arbiter for a resident/visitor gate pair with timeout,
// passage counting and a forced-entry/tailgating alarm that only a guard can clear.
module arbitro_cancelas #(
  parameter int T_ABERTA   = 8,
  parameter int T_PASSAGEM = 4
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       chega_morador,
  input  logic       chega_visitante,
  input  logic       sensor_morador,
  input  logic       sensor_visitante,
  input  logic       limpa_alarme,
  output logic       abre_morador,
  output logic       abre_visitante,
  output logic       alarme,
  output logic [2:0] estado,
  output logic [7:0] passagens
);
  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ABERTA_M = 3'd1,
    ABERTA_V = 3'd2,
    PASSANDO = 3'd3,
    ALARME   = 3'd4
  } estado_t;
  localparam logic M = 1'b0;
  localparam logic V = 1'b1;
  localparam logic [3:0] LIM_A = 4'(T_ABERTA - 1);
  localparam logic [3:0] LIM_P = 4'(T_PASSAGEM - 1);
  estado_t    st, st_n;
  logic [3:0] cnt, cnt_n;
  logic       dono, dono_n, ultimo, ultimo_n;
  logic [7:0] pass_n;
  logic       s_dono, s_outro;
  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    dono_n   = dono;
    ultimo_n = ultimo;
    pass_n   = passagens;
    s_dono   = dono ? sensor_visitante : sensor_morador;
    s_outro  = dono ? sensor_morador : sensor_visitante;
    case (st)
      OCIOSO:
        if (sensor_morador || sensor_visitante) st_n = ALARME;
        else if (chega_morador || chega_visitante) begin
          dono_n = (chega_morador && chega_visitante) ? ~ultimo : chega_visitante;
          st_n   = dono_n ? ABERTA_V : ABERTA_M;
          cnt_n  = '0;
        end
      ABERTA_M, ABERTA_V:
        if (s_outro) st_n = ALARME;
        else if (s_dono) begin
          st_n  = PASSANDO;
          cnt_n = '0;
        end
        else if (cnt == LIM_A) st_n = OCIOSO;
        else cnt_n = cnt + 4'd1;
      PASSANDO:
        if (s_outro) st_n = ALARME;
        else if (!s_dono) begin
          st_n     = OCIOSO;
          pass_n   = passagens + 8'd1;
          ultimo_n = dono;
        end
        else if (cnt == LIM_P) st_n = ALARME;
        else cnt_n = cnt + 4'd1;
      ALARME:
        if (limpa_alarme && !sensor_morador && !sensor_visitante) begin
          st_n  = OCIOSO;
          cnt_n = '0;
        end
      default: st_n = ALARME;
    endcase
  end
  // Outputs are decoded from the next state so they change on the same edge as estado.
  always_ff @(posedge clk_2 or posedge reset)
    if (reset) begin
      st             <= OCIOSO;
      cnt            <= '0;
      dono           <= M;
      ultimo         <= V;
      passagens      <= '0;
      abre_morador   <= 1'b0;
      abre_visitante <= 1'b0;
      alarme         <= 1'b0;
    end else begin
      st             <= st_n;
      cnt            <= cnt_n;
      dono           <= dono_n;
      ultimo         <= ultimo_n;
      passagens      <= pass_n;
      abre_morador   <= (st_n == ABERTA_M) || (st_n == PASSANDO && dono_n == M);
      abre_visitante <= (st_n == ABERTA_V) || (st_n == PASSANDO && dono_n == V);
      alarme         <= (st_n == ALARME);
    end
  assign estado = st;
endmodule

// File: tb/tb_arbitro_cancelas.sv
// tb_arbitro_cancelas: directed scenarios checked every cycle against a gate-occupancy model,
// plus literal expectations for each scenario.
module tb_arbitro_cancelas;
  localparam int TA = 8;
  localparam int TP = 4;
  logic       clk_2 = 1'b0, reset = 1'b1;
  logic       chega_morador = 0, chega_visitante = 0, sensor_morador = 0, sensor_visitante = 0, limpa_alarme = 0;
  logic       abre_morador, abre_visitante, alarme;
  logic [2:0] estado;
  logic [7:0] passagens;
  int         vectors = 0, fails = 0;
  bit         armed = 0;

  arbitro_cancelas #(.T_ABERTA(TA), .T_PASSAGEM(TP)) dut (
    .clk_2(clk_2), .reset(reset),
    .chega_morador(chega_morador), .chega_visitante(chega_visitante),
    .sensor_morador(sensor_morador), .sensor_visitante(sensor_visitante),
    .limpa_alarme(limpa_alarme),
    .abre_morador(abre_morador), .abre_visitante(abre_visitante),
    .alarme(alarme), .estado(estado), .passagens(passagens)
  );

  initial forever #5 clk_2 = ~clk_2;

  // gate: 0 none, 1 resident, 2 visitor; last: side of the last completed passage
  typedef struct {
    int gate;
    bit passing;
    bit alarm;
    int timer;
    int count;
    int last;
  } m_t;
  m_t m;

  function automatic m_t model_reset();
    m_t r;
    r.gate = 0; r.passing = 0; r.alarm = 0; r.timer = 0; r.count = 0; r.last = 2;
    return r;
  endfunction

  function automatic m_t model_step(m_t c, bit cm, bit cv, bit sm, bit sv, bit lim);
    m_t n = c;
    bit own, other;
    if (c.alarm) begin
      if (lim && !sm && !sv) begin n.alarm = 0; n.timer = 0; end
    end else if (c.gate == 0) begin
      if (sm || sv) n.alarm = 1;
      else if (cm || cv) begin
        n.gate  = (cm && cv) ? (c.last == 2 ? 1 : 2) : (cm ? 1 : 2);
        n.timer = 0;
      end
    end else begin
      own   = (c.gate == 1) ? sm : sv;
      other = (c.gate == 1) ? sv : sm;
      if (other || (c.passing && own && c.timer >= TP - 1)) begin
        n.alarm = 1; n.gate = 0; n.passing = 0;
      end else if (c.passing && !own) begin
        n.gate = 0; n.passing = 0; n.count = (c.count + 1) % 256; n.last = c.gate;
      end else if (!c.passing && own) begin
        n.passing = 1; n.timer = 0;
      end else if (!c.passing && c.timer >= TA - 1) n.gate = 0;
      else n.timer = c.timer + 1;
    end
    return n;
  endfunction

  always @(posedge clk_2 or posedge reset)
    if (reset) m <= model_reset();
    else m <= model_step(m, chega_morador, chega_visitante, sensor_morador, sensor_visitante, limpa_alarme);

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_2)
    if (armed) begin
      check("model abre_morador", 8'(abre_morador), 8'(!m.alarm && m.gate == 1));
      check("model abre_visitante", 8'(abre_visitante), 8'(!m.alarm && m.gate == 2));
      check("model alarme", 8'(alarme), 8'(m.alarm));
      check("model estado", 8'(estado), 8'(m.alarm ? 4 : m.gate == 0 ? 0 : m.passing ? 3 : m.gate));
      check("model passagens", passagens, 8'(m.count));
    end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk_2);
      #2;
    end
  endtask

  task automatic pulse_reset();
    reset = 1; tick(1); reset = 0; tick(1);
  endtask

  task automatic passagem_morador();
    chega_morador = 1; tick(1);
    chega_morador = 0; sensor_morador = 1; tick(1);
    sensor_morador = 0; tick(1);
  endtask

  task automatic limpa();
    sensor_morador = 0; sensor_visitante = 0; limpa_alarme = 1; tick(1);
    limpa_alarme = 0;
  endtask

  int grants[3];
  int n;

  initial begin
    tick(2);
    reset = 0;
    armed = 1;
    tick(1);
    check("reset estado", 8'(estado), 8'd0);
    check("reset passagens", passagens, 8'd0);
    check("reset gates", 8'({abre_morador, abre_visitante, alarme}), 8'd0);
    // single resident passage, sensor high for two edges
    chega_morador = 1; tick(1);
    chega_morador = 0;
    check("grant M abre", 8'(abre_morador), 8'd1);
    check("grant M estado", 8'(estado), 8'd1);
    sensor_morador = 1; tick(1);
    check("passando estado", 8'(estado), 8'd3);
    tick(1);
    check("passando abre", 8'(abre_morador), 8'd1);
    sensor_morador = 0; tick(1);
    check("passage count", passagens, 8'd1);
    check("model count", 8'(m.count), 8'd1);
    check("passage done estado", 8'(estado), 8'd0);
    check("passage done abre", 8'(abre_morador), 8'd0);
    // round-robin with both requests held
    pulse_reset();
    chega_morador = 1; chega_visitante = 1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      grants[i] = abre_morador ? 1 : abre_visitante ? 2 : 0;
      if (grants[i] == 1) sensor_morador = 1; else sensor_visitante = 1;
      tick(1);
      sensor_morador = 0; sensor_visitante = 0; chega_morador = (i < 2); chega_visitante = (i < 2);
      tick(1);
    end
    check("rr grant 0", 8'(grants[0]), 8'd1);
    check("rr grant 1", 8'(grants[1]), 8'd2);
    check("rr grant 2", 8'(grants[2]), 8'd1);
    check("rr passagens", passagens, 8'd3);
    // visitor timeout
    chega_visitante = 1; tick(1);
    chega_visitante = 0;
    n = 0;
    while (abre_visitante && n < 20) begin n++; tick(1); end
    check("timeout open cycles", 8'(n), 8'd8);
    check("timeout estado", 8'(estado), 8'd0);
    check("timeout passagens", passagens, 8'd3);
    // stalled passage raises the alarm; clear ignored while sensor is high
    chega_morador = 1; tick(1);
    chega_morador = 0; sensor_morador = 1; tick(1);
    tick(3);
    check("stall not yet", 8'(estado), 8'd3);
    tick(1);
    check("stall alarme", 8'(alarme), 8'd1);
    check("stall gates", 8'({abre_morador, abre_visitante}), 8'd0);
    limpa_alarme = 1; tick(2);
    check("clear ignored", 8'(estado), 8'd4);
    limpa_alarme = 0; sensor_morador = 0; tick(1);
    check("alarm held", 8'(alarme), 8'd1);
    limpa();
    check("alarm cleared", 8'(estado), 8'd0);
    check("stall passagens", passagens, 8'd3);
    // forced entry in idle and intrusion on the other gate
    sensor_visitante = 1; tick(1);
    check("forced entry", 8'(alarme), 8'd1);
    limpa();
    chega_morador = 1; tick(1);
    chega_morador = 0; sensor_visitante = 1; tick(1);
    check("intrusion alarme", 8'(alarme), 8'd1);
    check("intrusion gate", 8'(abre_morador), 8'd0);
    limpa();
    check("intrusion cleared", 8'(estado), 8'd0);
    // counter wrap
    pulse_reset();
    repeat (255) passagem_morador();
    check("preload 255", passagens, 8'd255);
    passagem_morador();
    check("wrap 0", passagens, 8'd0);
    // asynchronous reset mid-passage
    passagem_morador();
    chega_morador = 1; tick(1);
    chega_morador = 0; sensor_morador = 1; tick(2);
    check("pre-reset passagens", passagens, 8'd1);
    check("pre-reset gate", 8'(abre_morador), 8'd1);
    reset = 1; #1;
    check("async gates", 8'({abre_morador, abre_visitante, alarme}), 8'd0);
    check("async estado", 8'(estado), 8'd0);
    check("async passagens", passagens, 8'd0);
    sensor_morador = 0; tick(1);
    reset = 0; tick(2);
    check("after reset estado", 8'(estado), 8'd0);
    armed = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
